data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 142 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory with a fixed WAIT_STATES stall per access and misalignment rejection.
// Optional macro DMEM_BYTE_LANES_EN enables per-byte store lanes via byte_en.
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_en,
  output logic [31:0] mem_data_read,
  output logic        stall,
  output logic        misalign
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [0:0]    r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic          r_write;
  logic          r_read;

  logic [0:0]    w_state_nx;
  logic [3:0]    w_cnt_nx;
  logic          w_latch;
  logic          w_we;
  logic [AW-1:0] w_widx;
  logic [31:0]   w_wdata;
  logic [3:0]    w_wbe;
  logic [AW-1:0] w_idx;
  logic          w_req;
  logic          w_aligned;

  assign w_idx     = addr[AW+1:2];
  assign w_req     = mem_read | mem_write;
  assign w_aligned = (addr[1:0] == 2'b00);

  // Next-state, RAM write strobe and combinational outputs; reset masks everything.
  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_latch       = 1'b0;
    w_we          = 1'b0;
    w_widx        = w_idx;
    w_wdata       = write_data;
    w_wbe         = byte_en;
    stall         = 1'b0;
    misalign      = 1'b0;
    mem_data_read = 32'h0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (!w_aligned) begin
            misalign = 1'b1;
          end else if (WAIT_STATES == 0) begin
            if (mem_write) w_we = 1'b1;
            else           mem_data_read = r_mem[w_idx];
          end else begin
            w_latch    = 1'b1;
            w_cnt_nx   = 4'(WAIT_STATES - 1);
            w_state_nx = ST_WAIT;
            stall      = 1'b1;
          end
        end
      end
      default: begin
        if (r_cnt != 4'd0) begin
          stall    = 1'b1;
          w_cnt_nx = r_cnt - 4'd1;
        end else begin
          w_widx     = r_idx;
          w_wdata    = r_wdata;
          w_wbe      = r_be;
          w_we       = r_write;
          w_state_nx = ST_IDLE;
          if (r_read) mem_data_read = r_mem[r_idx];
        end
      end
    endcase
    if (!arst_n) begin
      w_latch       = 1'b0;
      w_we          = 1'b0;
      stall         = 1'b0;
      misalign      = 1'b0;
      mem_data_read = 32'h0;
    end
  end

  // State, counter and latched request.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_wdata <= 32'h0;
      r_be    <= 4'h0;
      r_write <= 1'b0;
      r_read  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_latch) begin
        r_idx   <= w_idx;
        r_wdata <= write_data;
        r_be    <= byte_en;
        r_write <= mem_write;
        r_read  <= mem_read & ~mem_write;
      end
    end
  end

  // RAM array; contents survive reset.
`ifdef DMEM_BYTE_LANES_EN
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wbe[i]) r_mem[w_widx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  logic w_unused;
  assign w_unused = ^addr[31:AW+2];
`else
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_widx] <= w_wdata;
  end

  logic w_unused;
  assign w_unused = ^{addr[31:AW+2], w_wbe};
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: three instances with WAIT_STATES = 2, 0 and 3.
module tb_data_mem_ctrl;

  logic        clk;
  logic [2:0]  rstn, rd, wr, st, mi;
  logic [31:0] ad [3];
  logic [31:0] wd [3];
  logic [3:0]  be [3];
  logic [31:0] dout [3];

  int n_checks = 0;
  int n_err    = 0;
  int bad_zero = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_w2 (
    .clk(clk), .arst_n(rstn[0]), .mem_read(rd[0]), .mem_write(wr[0]), .addr(ad[0]),
    .write_data(wd[0]), .byte_en(be[0]), .mem_data_read(dout[0]), .stall(st[0]), .misalign(mi[0]));
  data_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_w0 (
    .clk(clk), .arst_n(rstn[1]), .mem_read(rd[1]), .mem_write(wr[1]), .addr(ad[1]),
    .write_data(wd[1]), .byte_en(be[1]), .mem_data_read(dout[1]), .stall(st[1]), .misalign(mi[1]));
  data_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u_w3 (
    .clk(clk), .arst_n(rstn[2]), .mem_read(rd[2]), .mem_write(wr[2]), .addr(ad[2]),
    .write_data(wd[2]), .byte_en(be[2]), .mem_data_read(dout[2]), .stall(st[2]), .misalign(mi[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access on instance k, starting just after a falling edge; returns stall count, data, misalign.
  task automatic access(input int k, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output int nstall, output logic [31:0] q, output logic mis);
    bit done;
    nstall = 0;
    q      = 32'h0;
    done   = 1'b0;
    rd[k] = r; wr[k] = w; ad[k] = a; wd[k] = d; be[k] = b;
    #1;
    mis = mi[k];
    if (st[k]) begin
      nstall++;
      if (dout[k] !== 32'h0) bad_zero++;
    end else begin
      q    = dout[k];
      done = 1'b1;
    end
    @(negedge clk);
    rd[k] = 1'b0; wr[k] = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (st[k]) begin
        nstall++;
        if (dout[k] !== 32'h0) bad_zero++;
        @(negedge clk);
      end else begin
        q    = dout[k];
        done = 1'b1;
        @(negedge clk);
      end
    end
  endtask

  int          ns;
  logic [31:0] q;
  logic        m;

  initial begin
    rstn = 3'b000; rd = 3'b000; wr = 3'b000;
    for (int k = 0; k < 3; k++) begin ad[k] = 32'h0; wd[k] = 32'h0; be[k] = 4'hF; end
    @(negedge clk); @(negedge clk);
    rstn = 3'b111;
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_stall%0d", k), 32'(st[k]), 32'h0);
      check($sformatf("rst_mis%0d", k), 32'(mi[k]), 32'h0);
      check($sformatf("rst_data%0d", k), dout[k], 32'h0);
    end
    @(negedge clk);

    // W=2 store then load
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, ns, q, m);
    check("w2_sw_stall", 32'(ns), 32'd2);
    check("w2_sw_mis", 32'(m), 32'h0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, ns, q, m);
    check("w2_lw_stall", 32'(ns), 32'd2);
    check("w2_lw_data", q, 32'hDEADBEEF);

    // misaligned store: one-cycle pulse, no stall, RAM untouched
    access(0, 1'b0, 1'b1, 32'h13, 32'h0BADF00D, 4'hF, ns, q, m);
    check("mis_pulse", 32'(m), 32'h1);
    check("mis_stall", 32'(ns), 32'd0);
    check("mis_data", q, 32'h0);
    #1;
    check("mis_one_cycle", 32'(mi[0]), 32'h0);
    @(negedge clk);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, ns, q, m);
    check("mis_word_kept", q, 32'hDEADBEEF);

    // wrap-around modulo 1 KiB
    access(0, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 4'hF, ns, q, m);
    access(0, 1'b1, 1'b0, 32'h000, 32'h0, 4'hF, ns, q, m);
    check("wrap_data", q, 32'hA5A5A5A5);

    // read+write together behaves as a write with zero read data
    access(0, 1'b1, 1'b1, 32'h30, 32'h00000055, 4'hF, ns, q, m);
    check("rw_data_zero", q, 32'h0);
    check("rw_stall", 32'(ns), 32'd2);
    access(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'hF, ns, q, m);
    check("rw_written", q, 32'h00000055);

    // byte lanes
    access(0, 1'b0, 1'b1, 32'h08, 32'h11223344, 4'hF, ns, q, m);
    access(0, 1'b0, 1'b1, 32'h08, 32'hAABBCCDD, 4'b0101, ns, q, m);
    access(0, 1'b1, 1'b0, 32'h08, 32'h0, 4'hF, ns, q, m);
`ifdef DMEM_BYTE_LANES_EN
    check("lanes_data", q, 32'h11BB33DD);
`else
    check("lanes_data", q, 32'hAABBCCDD);
`endif

    // W=0: no stall, same-cycle data
    access(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, ns, q, m);
    check("w0_sw_stall", 32'(ns), 32'd0);
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, ns, q, m);
    check("w0_lw_stall", 32'(ns), 32'd0);
    check("w0_lw_data", q, 32'hDEADBEEF);
    #1;
    check("w0_idle_data", dout[1], 32'h0);
    @(negedge clk);

    // W=3: reset in the second WAIT cycle aborts the store
    access(2, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, ns, q, m);
    check("w3_pre_stall", 32'(ns), 32'd3);
    rd[2] = 1'b0; wr[2] = 1'b1; ad[2] = 32'h20; wd[2] = 32'h12345678;
    #1;
    check("w3_req_stall", 32'(st[2]), 32'h1);
    @(negedge clk);
    wr[2] = 1'b0;
    @(negedge clk);
    rstn[2] = 1'b0;
    @(negedge clk);
    rstn[2] = 1'b1;
    #1;
    check("w3_abort_stall", 32'(st[2]), 32'h0);
    @(negedge clk);
    access(2, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, ns, q, m);
    check("w3_old_value", q, 32'hCAFEF00D);
    check("w3_lw_stall", 32'(ns), 32'd3);

    check("data_zero_in_stall", 32'(bad_zero), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
